// File: rtl/uart_rx_ctrl_if.sv
// Signal bundle between the UART RX frame sequencer and its sampler/checker datapath.
// The master side is the sequencer; the slave side is the pin, sampler and checkers.
interface uart_rx_ctrl_if #(
   parameter int PRESCALE_W = 6
);
   logic                  RX_IN;
   logic                  PAR_EN;
   logic [PRESCALE_W-1:0] Prescale;
   logic                  sampled_bit;
   logic                  Parity_Error;
   logic                  data_samp_en;
   logic [PRESCALE_W-1:0] edge_cnt;
   logic [3:0]            bit_cnt;
   logic                  strt_chk_en;
   logic                  deser_en;
   logic                  par_chk_en;
   logic                  stp_chk_en;
   logic                  data_valid;
   logic                  Stop_Error;
   logic                  Frame_Par_Err;
   logic                  Start_Glitch;

   modport master (
      input  RX_IN, PAR_EN, Prescale, sampled_bit, Parity_Error,
      output data_samp_en, edge_cnt, bit_cnt, strt_chk_en, deser_en, par_chk_en,
             stp_chk_en, data_valid, Stop_Error, Frame_Par_Err, Start_Glitch
   );

   modport slave (
      output RX_IN, PAR_EN, Prescale, sampled_bit, Parity_Error,
      input  data_samp_en, edge_cnt, bit_cnt, strt_chk_en, deser_en, par_chk_en,
             stp_chk_en, data_valid, Stop_Error, Frame_Par_Err, Start_Glitch
   );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART RX frame sequencer: walks start/data/parity/stop bits with an oversampling edge counter,
// fires single-cycle checker enables at each bit end and flags every finished frame.
module uart_rx_ctrl #(
   parameter int OUT_data   = 8,
   parameter int PRESCALE_W = 6
) (
   input logic            CLK,
   input logic            RST,
   uart_rx_ctrl_if.master bus
);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   localparam logic [PRESCALE_W-1:0] PMIN     = PRESCALE_W'(8);
   localparam logic [3:0]            LAST_BIT = 4'(OUT_data - 1);

   state_t                state, state_n;
   logic [PRESCALE_W-1:0] edge_r, edge_n;
   logic [PRESCALE_W-1:0] presc_r, presc_n;
   logic [3:0]            bit_r, bit_n;
   logic                  par_en_r, par_en_n;
   logic                  par_fail_r, par_fail_n;
   logic                  dv_r, dv_n;
   logic                  se_r, se_n;
   logic                  fpe_r, fpe_n;
   logic                  sg_r, sg_n;
   logic                  bit_end;
   logic                  strt_en, deser, par_pulse, stp_en;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= IDLE;
         edge_r     <= '0;
         bit_r      <= '0;
         presc_r    <= PMIN;
         par_en_r   <= 1'b0;
         par_fail_r <= 1'b0;
         dv_r       <= 1'b0;
         se_r       <= 1'b0;
         fpe_r      <= 1'b0;
         sg_r       <= 1'b0;
      end else begin
         state      <= state_n;
         edge_r     <= edge_n;
         bit_r      <= bit_n;
         presc_r    <= presc_n;
         par_en_r   <= par_en_n;
         par_fail_r <= par_fail_n;
         dv_r       <= dv_n;
         se_r       <= se_n;
         fpe_r      <= fpe_n;
         sg_r       <= sg_n;
      end
   end

   always_comb begin
      state_n    = state;
      presc_n    = presc_r;
      par_en_n   = par_en_r;
      bit_n      = bit_r;
      par_fail_n = par_fail_r;
      dv_n       = 1'b0;
      se_n       = 1'b0;
      fpe_n      = 1'b0;
      sg_n       = 1'b0;
      strt_en    = 1'b0;
      deser      = 1'b0;
      par_pulse  = 1'b0;
      stp_en     = 1'b0;
      bit_end    = (state != IDLE) && (edge_r == presc_r - PRESCALE_W'(1));

      case (state)
         IDLE: begin
            bit_n      = '0;
            par_fail_n = 1'b0;
            // Frame parameters are frozen here so mid-frame changes cannot skew bit timing
            if (!bus.RX_IN) begin
               state_n  = START;
               par_en_n = bus.PAR_EN;
               presc_n  = (bus.Prescale < PMIN) ? PMIN : bus.Prescale;
            end
         end
         START: begin
            if (bit_end) begin
               strt_en = 1'b1;
               if (bus.sampled_bit) begin
                  sg_n    = 1'b1;
                  state_n = IDLE;
               end else begin
                  state_n = DATA;
                  bit_n   = '0;
               end
            end
         end
         DATA: begin
            if (bit_end) begin
               deser = 1'b1;
               if (bit_r == LAST_BIT) begin
                  bit_n   = '0;
                  state_n = par_en_r ? PARITY : STOP;
               end else begin
                  bit_n = bit_r + 4'd1;
               end
            end
         end
         PARITY: begin
            if (bit_end) begin
               par_pulse = 1'b1;
               state_n   = STOP;
            end
         end
         STOP: begin
            // parity_check answers one cycle after par_chk_en, i.e. at the first STOP edge
            if (par_en_r && edge_r == '0) par_fail_n = bus.Parity_Error;
            if (bit_end) begin
               stp_en  = 1'b1;
               state_n = IDLE;
               dv_n    = bus.sampled_bit & ~par_fail_r;
               se_n    = ~bus.sampled_bit;
               fpe_n   = par_fail_r;
            end
         end
         default: state_n = IDLE;
      endcase

      if (state_n == IDLE || bit_end || state_n != state) edge_n = '0;
      else                                                 edge_n = edge_r + PRESCALE_W'(1);
   end

   assign bus.data_samp_en  = (state != IDLE);
   assign bus.edge_cnt      = edge_r;
   assign bus.bit_cnt       = bit_r;
   assign bus.strt_chk_en   = strt_en;
   assign bus.deser_en      = deser;
   assign bus.par_chk_en    = par_pulse;
   assign bus.stp_chk_en    = stp_en;
   assign bus.data_valid    = dv_r;
   assign bus.Stop_Error    = se_r;
   assign bus.Frame_Par_Err = fpe_r;
   assign bus.Start_Glitch  = sg_r;

endmodule
